// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared constants and Gray/binary conversion helpers for the
//                dual-clock FIFO pointer logic.
//  Revision    : 1.0  initial release
// ============================================================================
package fifo_pkg;

  localparam int DEFAULT_ADDRESS_SIZE = 4;
  localparam int DEPTH                = 2 ** DEFAULT_ADDRESS_SIZE;

  // Helpers operate on a 32-bit carrier; callers zero-extend their pointer,
  // pass its real width, and truncate the result back.
  function automatic logic [31:0] bin2gray(input logic [31:0] b, input int unsigned width);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < int'(width)) v[i] = b[i];
    end
    return (v >> 1) ^ v;
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g, input int unsigned width);
    logic [31:0] b;
    logic        acc;
    b   = '0;
    acc = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (i < int'(width)) begin
        acc  = acc ^ g[i];
        b[i] = acc;
      end
    end
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_read2write.sv
`default_nettype none
// ============================================================================
//  Module      : sync_read2write
//  Description : Two-flop synchronizer bringing the read-domain Gray pointer
//                into the write clock domain. No logic between stages.
//  Revision    : 1.0  initial release
// ============================================================================
module sync_read2write #(
  parameter int WIDTH = 5
) (
  input  logic             wclk,
  input  logic             wrst,
  input  logic [WIDTH-1:0] read_ptr,
  output logic [WIDTH-1:0] wq2_rptr
);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;

  // Two back-to-back capture stages; only one Gray bit moves per step.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= read_ptr;
      r_sync2 <= r_sync1;
    end
  end

  assign wq2_rptr = r_sync2;

endmodule
`default_nettype wire

// File: rtl/write_ptr_full.sv
`default_nettype none
// ============================================================================
//  Module      : write_ptr_full
//  Description : Write-domain pointer pair, full / almost-full / level status
//                and sticky overflow for the dual-clock FIFO.
//  Revision    : 1.0  initial release
// ============================================================================
module write_ptr_full
  import fifo_pkg::*;
#(
  parameter int ADDRESS_SIZE = DEFAULT_ADDRESS_SIZE,
  parameter int AF_MARGIN    = 2
) (
  input  logic                    wclk,
  input  logic                    wrst,
  input  logic                    winc,
  input  logic [ADDRESS_SIZE:0]   read_ptr,
  output logic [ADDRESS_SIZE:0]   write_ptr,
  output logic [ADDRESS_SIZE-1:0] write_addr,
  output logic                    wen,
  output logic                    wfull,
  output logic                    walmost_full,
  output logic [ADDRESS_SIZE:0]   wlevel,
  output logic                    woverflow
);

  localparam int c_PW        = ADDRESS_SIZE + 1;
  localparam int c_DEPTH     = 2 ** ADDRESS_SIZE;
  localparam int c_AF_THRESH = c_DEPTH - AF_MARGIN;

  logic [c_PW-1:0] r_bin;
  logic [c_PW-1:0] r_gray;
  logic            r_full;
  logic            r_afull;
  logic [c_PW-1:0] r_level;
  logic            r_ovf;

  logic [c_PW-1:0] w_wq2_rptr;
  logic [c_PW-1:0] w_rbin_s;
  logic            w_accept;
  logic [c_PW-1:0] w_bin_next;
  logic [c_PW-1:0] w_gray_next;
  logic [c_PW-1:0] w_full_pattern;
  logic            w_full_next;
  logic [c_PW-1:0] w_level_next;
  logic            w_afull_next;

  sync_read2write #(
    .WIDTH (c_PW)
  ) u_sync (
    .wclk     (wclk),
    .wrst     (wrst),
    .read_ptr (read_ptr),
    .wq2_rptr (w_wq2_rptr)
  );

  // Next-pointer, full-compare and level arithmetic, all modulo 2*depth.
  always_comb begin
    w_accept       = winc & ~r_full;
    w_bin_next     = r_bin + c_PW'(w_accept);
    w_gray_next    = c_PW'(bin2gray(32'(w_bin_next), c_PW));
    w_rbin_s       = c_PW'(gray2bin(32'(w_wq2_rptr), c_PW));
    // Full when the write pointer has lapped the read pointer exactly once:
    // top two Gray bits inverted, the rest equal.
    w_full_pattern = {~w_wq2_rptr[c_PW-1:c_PW-2], w_wq2_rptr[c_PW-3:0]};
    w_full_next    = (w_gray_next == w_full_pattern);
    w_level_next   = w_bin_next - w_rbin_s;
    w_afull_next   = (w_level_next >= c_PW'(c_AF_THRESH));
  end

  // Pointer, status and sticky overflow registers.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      r_bin   <= '0;
      r_gray  <= '0;
      r_full  <= 1'b0;
      r_afull <= 1'b0;
      r_level <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_bin   <= w_bin_next;
      r_gray  <= w_gray_next;
      r_full  <= w_full_next;
      r_afull <= w_afull_next;
      r_level <= w_level_next;
      r_ovf   <= r_ovf | (winc & r_full);
    end
  end

  // The RAM enable is also held off while reset is asserted so no write
  // reaches the array during reset; pointer flops ignore it while in reset.
  assign wen          = winc & ~r_full & ~wrst;
  assign write_ptr    = r_gray;
  assign write_addr   = r_bin[ADDRESS_SIZE-1:0];
  assign wfull        = r_full;
  assign walmost_full = r_afull;
  assign wlevel       = r_level;
  assign woverflow    = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_write_ptr_full.sv
`default_nettype none
// ============================================================================
//  Module      : tb_write_ptr_full
//  Description : Self-checking bench for write_ptr_full (ADDRESS_SIZE=4,
//                AF_MARGIN=2): table-driven fill/overflow/drain plus
//                hand-written reset, wrap and mid-operation reset sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_write_ptr_full;

  logic       wclk;
  logic       wrst;
  logic       winc;
  logic [4:0] read_ptr;
  logic [4:0] write_ptr;
  logic [3:0] write_addr;
  logic       wen;
  logic       wfull;
  logic       walmost_full;
  logic [4:0] wlevel;
  logic       woverflow;

  int n_vec;
  int n_err;

  write_ptr_full #(
    .ADDRESS_SIZE (4),
    .AF_MARGIN    (2)
  ) dut (
    .wclk         (wclk),
    .wrst         (wrst),
    .winc         (winc),
    .read_ptr     (read_ptr),
    .write_ptr    (write_ptr),
    .write_addr   (write_addr),
    .wen          (wen),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wlevel       (wlevel),
    .woverflow    (woverflow)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  typedef struct {
    logic       winc;
    logic [4:0] rptr;
    logic       exp_wen;
    logic [4:0] exp_wptr;
    logic [3:0] exp_addr;
    logic       exp_full;
    logic       exp_af;
    logic [4:0] exp_lvl;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[24];

  function automatic logic [4:0] g(input int b);
    logic [4:0] v;
    v = 5'(b);
    return (v >> 1) ^ v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".write_ptr"},    32'(write_ptr),    32'd0);
    chk({tag, ".write_addr"},   32'(write_addr),   32'd0);
    chk({tag, ".wfull"},        32'(wfull),        32'd0);
    chk({tag, ".walmost_full"}, 32'(walmost_full), 32'd0);
    chk({tag, ".wlevel"},       32'(wlevel),       32'd0);
    chk({tag, ".woverflow"},    32'(woverflow),    32'd0);
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    string t;
    t = $sformatf("vec%0d", idx);
    @(negedge wclk);
    winc     = v.winc;
    read_ptr = v.rptr;
    #1;
    chk({t, ".wen"}, 32'(wen), 32'(v.exp_wen));
    @(posedge wclk);
    #1;
    chk({t, ".write_ptr"},    32'(write_ptr),    32'(v.exp_wptr));
    chk({t, ".write_addr"},   32'(write_addr),   32'(v.exp_addr));
    chk({t, ".wfull"},        32'(wfull),        32'(v.exp_full));
    chk({t, ".walmost_full"}, 32'(walmost_full), 32'(v.exp_af));
    chk({t, ".wlevel"},       32'(wlevel),       32'(v.exp_lvl));
    chk({t, ".woverflow"},    32'(woverflow),    32'(v.exp_ovf));
  endtask

  task automatic do_reset();
    @(negedge wclk);
    wrst     = 1'b1;
    winc     = 1'b0;
    read_ptr = '0;
    @(negedge wclk);
    wrst = 1'b0;
  endtask

  initial begin
    logic [4:0] prev_ptr;
    logic       saw_wrap;
    n_vec = 0;
    n_err = 0;

    // Fill from empty with read_ptr held at 0: writes 1..16.
    //            winc rptr      wen  wptr      addr   full af   lvl       ovf
    vecs[0]  = '{1'b1, 5'b00000, 1'b1, 5'b00001, 4'd1,  1'b0, 1'b0, 5'd1,  1'b0};
    vecs[1]  = '{1'b1, 5'b00000, 1'b1, 5'b00011, 4'd2,  1'b0, 1'b0, 5'd2,  1'b0};
    vecs[2]  = '{1'b1, 5'b00000, 1'b1, 5'b00010, 4'd3,  1'b0, 1'b0, 5'd3,  1'b0};
    vecs[3]  = '{1'b1, 5'b00000, 1'b1, 5'b00110, 4'd4,  1'b0, 1'b0, 5'd4,  1'b0};
    vecs[4]  = '{1'b1, 5'b00000, 1'b1, 5'b00111, 4'd5,  1'b0, 1'b0, 5'd5,  1'b0};
    vecs[5]  = '{1'b1, 5'b00000, 1'b1, 5'b00101, 4'd6,  1'b0, 1'b0, 5'd6,  1'b0};
    vecs[6]  = '{1'b1, 5'b00000, 1'b1, 5'b00100, 4'd7,  1'b0, 1'b0, 5'd7,  1'b0};
    vecs[7]  = '{1'b1, 5'b00000, 1'b1, 5'b01100, 4'd8,  1'b0, 1'b0, 5'd8,  1'b0};
    vecs[8]  = '{1'b1, 5'b00000, 1'b1, 5'b01101, 4'd9,  1'b0, 1'b0, 5'd9,  1'b0};
    vecs[9]  = '{1'b1, 5'b00000, 1'b1, 5'b01111, 4'd10, 1'b0, 1'b0, 5'd10, 1'b0};
    vecs[10] = '{1'b1, 5'b00000, 1'b1, 5'b01110, 4'd11, 1'b0, 1'b0, 5'd11, 1'b0};
    vecs[11] = '{1'b1, 5'b00000, 1'b1, 5'b01010, 4'd12, 1'b0, 1'b0, 5'd12, 1'b0};
    vecs[12] = '{1'b1, 5'b00000, 1'b1, 5'b01011, 4'd13, 1'b0, 1'b0, 5'd13, 1'b0};
    vecs[13] = '{1'b1, 5'b00000, 1'b1, 5'b01001, 4'd14, 1'b0, 1'b1, 5'd14, 1'b0};
    vecs[14] = '{1'b1, 5'b00000, 1'b1, 5'b01000, 4'd15, 1'b0, 1'b1, 5'd15, 1'b0};
    vecs[15] = '{1'b1, 5'b00000, 1'b1, 5'b11000, 4'd0,  1'b1, 1'b1, 5'd16, 1'b0};
    // Overflow: three writes while full are dropped, sticky flag sets.
    vecs[16] = '{1'b1, 5'b00000, 1'b0, 5'b11000, 4'd0,  1'b1, 1'b1, 5'd16, 1'b1};
    vecs[17] = '{1'b1, 5'b00000, 1'b0, 5'b11000, 4'd0,  1'b1, 1'b1, 5'd16, 1'b1};
    vecs[18] = '{1'b1, 5'b00000, 1'b0, 5'b11000, 4'd0,  1'b1, 1'b1, 5'd16, 1'b1};
    // Drain visibility: read_ptr -> 00001 shows up on the third edge.
    vecs[19] = '{1'b0, 5'b00001, 1'b0, 5'b11000, 4'd0,  1'b1, 1'b1, 5'd16, 1'b1};
    vecs[20] = '{1'b0, 5'b00001, 1'b0, 5'b11000, 4'd0,  1'b1, 1'b1, 5'd16, 1'b1};
    vecs[21] = '{1'b0, 5'b00001, 1'b0, 5'b11000, 4'd0,  1'b0, 1'b1, 5'd15, 1'b1};
    // One more write refills the freed slot; full again, overflow still held.
    vecs[22] = '{1'b1, 5'b00001, 1'b1, 5'b11001, 4'd1,  1'b1, 1'b1, 5'd16, 1'b1};
    vecs[23] = '{1'b0, 5'b00001, 1'b0, 5'b11001, 4'd1,  1'b1, 1'b1, 5'd16, 1'b1};

    // Reset held with writes requested and a wandering read pointer.
    wrst     = 1'b1;
    winc     = 1'b1;
    read_ptr = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge wclk);
      read_ptr = 5'($urandom_range(0, 31));
      #1;
      chk("rst.wen", 32'(wen), 32'd0);
      @(posedge wclk);
      #1;
      chk_all_zero("rst");
    end
    @(negedge wclk);
    winc     = 1'b0;
    read_ptr = '0;
    wrst     = 1'b0;

    for (int i = 0; i < 24; i++) apply_vec(vecs[i], i);

    // Overflow stays sticky until reset, then clears.
    do_reset();
    #1;
    chk("ovf_clear.woverflow", 32'(woverflow), 32'd0);

    // Wrap: 44 writes with read pointer trailing by 4 once settled.
    saw_wrap = 1'b0;
    prev_ptr = '0;
    for (int n = 0; n < 44; n++) begin
      @(negedge wclk);
      winc     = 1'b1;
      read_ptr = (n + 1 >= 4) ? g(n + 1 - 4) : 5'b00000;
      @(negedge wclk);
      winc = 1'b0;
      for (int k = 0; k < 3; k++) begin
        @(posedge wclk);
        #1;
        chk($sformatf("wrap%0d.wfull", n), 32'(wfull), 32'd0);
      end
      chk($sformatf("wrap%0d.write_ptr", n), 32'(write_ptr), 32'(g(n + 1)));
      if (n + 1 >= 4)
        chk($sformatf("wrap%0d.wlevel", n), 32'(wlevel), 32'd4);
      if (prev_ptr == 5'b10000 && write_ptr == 5'b00000) saw_wrap = 1'b1;
      prev_ptr = write_ptr;
    end
    chk("wrap.seen_10000_to_00000", 32'(saw_wrap), 32'd1);

    // Mid-operation asynchronous reset at level 9.
    do_reset();
    @(negedge wclk);
    winc = 1'b1;
    repeat (9) @(posedge wclk);
    @(negedge wclk);
    winc = 1'b0;
    #1;
    chk("mid.wlevel_before", 32'(wlevel), 32'd9);
    @(posedge wclk);
    #3;
    wrst = 1'b1;
    #1;
    chk_all_zero("mid");
    #2;
    wrst = 1'b0;
    @(negedge wclk);
    winc = 1'b1;
    @(posedge wclk);
    #1;
    chk("resume.wlevel",    32'(wlevel),    32'd1);
    chk("resume.write_ptr", 32'(write_ptr), 32'd1);
    @(negedge wclk);
    winc = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
